// File: rtl/operand_decomposer.sv
// Splits two IEEE-754 single-precision operands into sign, exponent and fraction.
// It also flags infinity/NaN, finds the larger magnitude and computes a saturated alignment shift.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   data_valid_i, x_i, y_i   : operand pair in, accepted only while idle
//   busy_o                   : high while a pair is in flight
//   data_valid_o             : one-cycle pulse, decomposed outputs valid
//   x/y_sign_o, x/y_exp_o, x/y_frac_o : raw fields
//   x_greater_o              : |x| >= |y|
//   exp_shift_o              : |x_exp - y_exp| saturated to SHIFT_SAT
//   x/y_infinity_o, x/y_nan_o: special-value flags
module operand_decomposer #(
    parameter logic [7:0] SHIFT_SAT = 8'd24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_valid_i,
    output logic        busy_o,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic        data_valid_o,
    output logic        x_sign_o,
    output logic        y_sign_o,
    output logic [7:0]  x_exp_o,
    output logic [7:0]  y_exp_o,
    output logic [22:0] x_frac_o,
    output logic [22:0] y_frac_o,
    output logic        x_greater_o,
    output logic [7:0]  exp_shift_o,
    output logic        x_infinity_o,
    output logic        y_infinity_o,
    output logic        x_nan_o,
    output logic        y_nan_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_x;
    logic [31:0] r_y;

    // Decoded fields are staged internally so the visible outputs
    // only move at the COMPARE->DONE edge.
    logic        r_xs;
    logic        r_ys;
    logic [7:0]  r_xe;
    logic [7:0]  r_ye;
    logic [22:0] r_xf;
    logic [22:0] r_yf;
    logic        r_xinf;
    logic        r_yinf;
    logic        r_xnan;
    logic        r_ynan;

    logic [8:0]  w_diff;
    logic [7:0]  w_shift;
    logic        w_x_greater;

    // Exponent then fraction compare is a plain magnitude compare.
    assign w_x_greater = (r_xe > r_ye) ||
                         ((r_xe == r_ye) && (r_xf >= r_yf));

    assign w_diff = (r_xe >= r_ye) ?
                    ({1'b0, r_xe} - {1'b0, r_ye}) :
                    ({1'b0, r_ye} - {1'b0, r_xe});

    assign w_shift = (w_diff > {1'b0, SHIFT_SAT}) ?
                     SHIFT_SAT : w_diff[7:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_xs         <= 1'b0;
            r_ys         <= 1'b0;
            r_xe         <= '0;
            r_ye         <= '0;
            r_xf         <= '0;
            r_yf         <= '0;
            r_xinf       <= 1'b0;
            r_yinf       <= 1'b0;
            r_xnan       <= 1'b0;
            r_ynan       <= 1'b0;
            busy_o       <= 1'b0;
            data_valid_o <= 1'b0;
            x_sign_o     <= 1'b0;
            y_sign_o     <= 1'b0;
            x_exp_o      <= '0;
            y_exp_o      <= '0;
            x_frac_o     <= '0;
            y_frac_o     <= '0;
            x_greater_o  <= 1'b0;
            exp_shift_o  <= '0;
            x_infinity_o <= 1'b0;
            y_infinity_o <= 1'b0;
            x_nan_o      <= 1'b0;
            y_nan_o      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (data_valid_i) begin
                        r_x     <= x_i;
                        r_y     <= y_i;
                        busy_o  <= 1'b1;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_xs    <= r_x[31];
                    r_ys    <= r_y[31];
                    r_xe    <= r_x[30:23];
                    r_ye    <= r_y[30:23];
                    r_xf    <= r_x[22:0];
                    r_yf    <= r_y[22:0];
                    r_xinf  <= (&r_x[30:23]) && (r_x[22:0] == '0);
                    r_yinf  <= (&r_y[30:23]) && (r_y[22:0] == '0);
                    r_xnan  <= (&r_x[30:23]) && (r_x[22:0] != '0);
                    r_ynan  <= (&r_y[30:23]) && (r_y[22:0] != '0);
                    r_state <= COMPARE;
                end
                COMPARE: begin
                    x_sign_o     <= r_xs;
                    y_sign_o     <= r_ys;
                    x_exp_o      <= r_xe;
                    y_exp_o      <= r_ye;
                    x_frac_o     <= r_xf;
                    y_frac_o     <= r_yf;
                    x_greater_o  <= w_x_greater;
                    exp_shift_o  <= w_shift;
                    x_infinity_o <= r_xinf;
                    y_infinity_o <= r_yinf;
                    x_nan_o      <= r_xnan;
                    y_nan_o      <= r_ynan;
                    data_valid_o <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    data_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/operand_decomposer.md
OPERAND_DECOMPOSER -- requirements
Module: operand_decomposer

Interface
REQ-001 The block SHALL have one parameter: SHIFT_SAT, default 8'd24, the saturation ceiling for exp_shift_o.
REQ-002 The block SHALL have these ports, one per line as follows:
- clk_i  input  1  sole clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- data_valid_i  input  1  x_i/y_i valid this cycle.
- busy_o  output  1  high while an operand pair is in flight; data_valid_i is ignored while high.
- x_i, y_i  input  32  IEEE-754 single-precision operands.
- data_valid_o  output  1  one-cycle pulse; all decomposed outputs are valid.
- x_sign_o, y_sign_o  output  1  sign bits.
- x_exp_o, y_exp_o  output  8  biased exponents.
- x_frac_o, y_frac_o  output  23  fraction fields.
- x_greater_o  output  1  x has magnitude greater than or equal to y.
- exp_shift_o  output  8  alignment shift for the smaller operand.
- x_infinity_o, y_infinity_o  output  1  operand is infinity.
- x_nan_o, y_nan_o  output  1  operand is NaN.

Function
REQ-003 The FSM SHALL have the states IDLE, DECODE, COMPARE and DONE; reset state is IDLE.
REQ-004 IDLE: when data_valid_i=1, the block SHALL register x_i and y_i, assert busy_o and go to DECODE; when data_valid_i=0 it SHALL stay in IDLE.
REQ-005 DECODE SHALL split each operand into sign [31], exp [30:23] and frac [22:0].
- infinity = (exp==8'hFF && frac==0).
- nan = (exp==8'hFF && frac!=0).
- DECODE then goes to COMPARE.
REQ-006 COMPARE SHALL set x_greater = (x_exp>y_exp) || (x_exp==y_exp && x_frac>=y_frac); ties resolve to x.
REQ-007 COMPARE SHALL set exp_shift = |x_exp - y_exp|, computed unsigned at 9-bit width and then saturated to SHIFT_SAT.
REQ-008 COMPARE SHALL go to DONE.
REQ-009 DONE SHALL assert data_valid_o for exactly one cycle, deassert busy_o, and return to IDLE.
REQ-010 Latency SHALL be fixed: data_valid_i sampled in cycle N gives data_valid_o high in cycle N+3.
REQ-011 The maximum rate SHALL be one operand pair every 4 cycles.
- A data_valid_i pulse in the same cycle as DONE is ignored.
- Back-to-back accepts are possible from the IDLE cycle that follows DONE.
REQ-012 All decomposed outputs SHALL be registered and SHALL hold their values from DONE until the next DONE; they never change mid-transaction.
REQ-013 data_valid_i asserted while busy_o=1 SHALL be ignored with no effect on in-flight data.
REQ-014 Zero and denormal operands SHALL be passed through unmodified with no flags raised; the downstream stage is responsible for them.
REQ-015 An operand that is both exp==FF and frac==0 SHALL never raise the nan flag, and infinity and nan SHALL be mutually exclusive per operand.

Reset
REQ-016 Asserting rst_i low SHALL immediately, asynchronously: force state to IDLE, clear busy_o and data_valid_o, and clear every decomposed output and flag to 0.
REQ-017 A reset mid-transaction SHALL abort it with no data_valid_o pulse, either during reset or after release.
REQ-018 After rst_i rises, the block SHALL accept data_valid_i no earlier than the first rising clock edge.

Verification
REQ-019 x=3F800000, y=40000000 -> x_greater_o=0, exp_shift_o=1, x_exp_o=7F, y_exp_o=80, data_valid_o exactly 3 cycles after accept.
REQ-020 x=y=40490FDB -> x_greater_o=1, exp_shift_o=0, both frac=490FDB, no flags.
REQ-021 x=7F800000, y=FFC00000 -> x_infinity_o=1, x_nan_o=0, y_nan_o=1, y_sign_o=1, y_infinity_o=0.
REQ-022 x=7F000000, y=00800000 -> x_greater_o=1, exp_shift_o=24 (saturated from 253).
REQ-023 Accept a pair, pulse data_valid_i again at cycle +1 -> second request ignored and outputs reflect only the first pair.
- Separately, drive rst_i low at cycle +2 -> no data_valid_o pulse, all outputs 0, busy_o=0.
